// File: rtl/if_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_prefetch_queue
// Description : Instruction fetch stage with next-PC selection, a req/ready
//               instruction-memory port tolerating wait states, and a
//               DEPTH-entry prefetch FIFO feeding ID over valid/ready.
//               A redirect flushes the FIFO and discards any in-flight word.
//               Optional macro IF_BYPASS_EN: a response arriving while the
//               FIFO is empty is presented to ID in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module if_prefetch_queue #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [1:0]             pc_select,
   input  logic [ADDR_W-1:0]      pc_b,
   input  logic [ADDR_W-1:0]      pc_r,
   input  logic [ADDR_W-1:0]      pc_j,
   output logic                   mem_req,
   output logic [ADDR_W-1:0]      mem_addr,
   input  logic                   mem_ready,
   input  logic [DATA_W-1:0]      mem_rdata,
   output logic                   valid_out,
   input  logic                   ready_in,
   output logic [DATA_W-1:0]      instr,
   output logic [ADDR_W-1:0]      pc_out,
   output logic [ADDR_W-1:0]      pc4,
   output logic [$clog2(DEPTH):0] level
);

   localparam int                 c_PTR_W = $clog2(DEPTH);
   localparam int                 c_LVL_W = c_PTR_W + 1;
   localparam logic [c_LVL_W-1:0] c_FULL  = c_LVL_W'(DEPTH);
   localparam logic [ADDR_W-1:0]  c_STEP  = ADDR_W'(4);

   logic [ADDR_W-1:0]  r_fetch_pc;
   logic [ADDR_W-1:0]  r_hold_addr;   // address presented last cycle
   logic               r_pending;     // request raised but not yet answered
   logic               r_discard;     // outstanding response belongs to a stale path
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_LVL_W-1:0] r_level;
   logic [ADDR_W-1:0]  r_fifo_pc   [DEPTH];
   logic [DATA_W-1:0]  r_fifo_data [DEPTH];

   logic               w_redirect;
   logic [ADDR_W-1:0]  w_target;
   logic               w_mem_req;
   logic [ADDR_W-1:0]  w_mem_addr;
   logic               w_resp;
   logic               w_fifo_valid;
   logic               w_bypass;
   logic               w_push;
   logic               w_pop;

   assign w_redirect   = (pc_select != 2'b00);
   assign w_fifo_valid = (r_level != '0);

   // Redirect target chosen by pc_select (sequential case unused).
   always_comb begin
      w_target = '0;
      case (pc_select)
         2'd1:    w_target = pc_b;
         2'd2:    w_target = pc_r;
         2'd3:    w_target = pc_j;
         default: w_target = '0;
      endcase
   end

   // An unanswered request is held regardless of FIFO state or redirects;
   // otherwise a new one is issued whenever a slot is free. Request is
   // forced low while reset is asserted.
   assign w_mem_req  = !reset && (r_pending || (r_level < c_FULL));
   assign w_mem_addr = r_pending ? r_hold_addr : r_fetch_pc;
   assign w_resp     = w_mem_req && mem_ready;

`ifdef IF_BYPASS_EN
   assign w_bypass = w_resp && !w_fifo_valid && !r_discard && !w_redirect;
`else
   assign w_bypass = 1'b0;
`endif

   // A bypassed word taken by ID the same cycle never enters the FIFO.
   assign w_push = w_resp && !r_discard && !w_redirect && !(w_bypass && ready_in);
   assign w_pop  = w_fifo_valid && ready_in && !w_redirect;

   assign mem_req  = w_mem_req;
   assign mem_addr = w_mem_addr;
   assign level    = r_level;

   // Head-of-queue view toward ID, zeroed when nothing is valid.
   always_comb begin
      valid_out = 1'b0;
      instr     = '0;
      pc_out    = '0;
      if (w_fifo_valid) begin
         valid_out = 1'b1;
         instr     = r_fifo_data[r_rd_ptr];
         pc_out    = r_fifo_pc[r_rd_ptr];
      end else if (w_bypass) begin
         valid_out = 1'b1;
         instr     = mem_rdata;
         pc_out    = w_mem_addr;
      end
   end

   assign pc4 = valid_out ? (pc_out + c_STEP) : '0;

   // Fetch PC, request tracking, discard flag and FIFO pointers/occupancy.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_fetch_pc  <= RESET_PC;
         r_hold_addr <= RESET_PC;
         r_pending   <= 1'b0;
         r_discard   <= 1'b0;
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_level     <= '0;
      end else begin
         r_hold_addr <= w_mem_addr;
         r_pending   <= w_mem_req && !mem_ready;
         if (w_redirect) begin
            r_fetch_pc <= w_target;
            r_discard  <= w_mem_req && !mem_ready;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_level    <= '0;
         end else begin
            if (w_resp) begin
               r_discard <= 1'b0;
               if (!r_discard) begin
                  r_fetch_pc <= r_fetch_pc + c_STEP;
               end
            end
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
               2'b10:   r_level <= r_level + 1'b1;
               2'b01:   r_level <= r_level - 1'b1;
               default: r_level <= r_level;
            endcase
         end
      end
   end

   // FIFO storage; contents are only observed through valid entries.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_fifo_pc[r_wr_ptr]   <= w_mem_addr;
         r_fifo_data[r_wr_ptr] <= mem_rdata;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_prefetch_queue
// Description : Self-checking bench for if_prefetch_queue with a queue-based
//               reference model; directed scenarios followed by random
//               traffic. Honours IF_BYPASS_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_prefetch_queue;

   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0000_0100;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  pc_select = '0;
   logic [31:0] pc_b = '0, pc_r = '0, pc_j = '0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        valid_out;
   logic        ready_in = 1'b0;
   logic [31:0] instr, pc_out, pc4;
   logic [2:0]  level;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [31:0] q_pc[$];
   logic [31:0] q_d[$];
   logic [31:0] m_fetch, m_pend_addr;
   logic        m_pend, m_disc;

   // last observed outputs
   logic        o_req, o_val;
   logic [31:0] o_addr, o_pc, o_pc4, o_instr, o_level;

   if_prefetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
      .clock(clock), .reset(reset), .pc_select(pc_select),
      .pc_b(pc_b), .pc_r(pc_r), .pc_j(pc_j),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .valid_out(valid_out), .ready_in(ready_in), .instr(instr),
      .pc_out(pc_out), .pc4(pc4), .level(level)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic capture();
      o_req = mem_req; o_addr = mem_addr; o_val = valid_out;
      o_pc = pc_out; o_pc4 = pc4; o_instr = instr; o_level = {29'd0, level};
   endtask

   // Asynchronous reset mid-cycle, checks reset values, releases after an edge.
   task automatic do_reset();
      reset = 1'b1;
      #2;
      capture();
      chk("rst_req",   {31'd0, o_req}, 32'd0);
      chk("rst_valid", {31'd0, o_val}, 32'd0);
      chk("rst_level", o_level, 32'd0);
      chk("rst_instr", o_instr, 32'd0);
      chk("rst_pc",    o_pc, 32'd0);
      chk("rst_pc4",   o_pc4, 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      q_pc.delete(); q_d.delete();
      m_fetch = RPC; m_pend = 1'b0; m_pend_addr = RPC; m_disc = 1'b0;
   endtask

   // One clock: drive inputs, compare against model at negedge, advance model.
   task automatic cycle(input logic [1:0] sel, input logic mr, input logic ri, input logic [31:0] rd);
      logic        e_req, e_val, resp, was_empty;
      logic [31:0] e_addr, e_pc, e_d, tgt;
      pc_select = sel; mem_ready = mr; ready_in = ri; mem_rdata = rd;
      e_req  = m_pend || (q_pc.size() < DEPTH);
      e_addr = m_pend ? m_pend_addr : m_fetch;
      resp   = e_req && mr;
      was_empty = (q_pc.size() == 0);
      e_val = 1'b0; e_pc = '0; e_d = '0;
      if (!was_empty) begin
         e_val = 1'b1; e_pc = q_pc[0]; e_d = q_d[0];
      end
`ifdef IF_BYPASS_EN
      else if (resp && !m_disc && sel == 2'd0) begin
         e_val = 1'b1; e_pc = e_addr; e_d = rd;
      end
`endif
      tgt = (sel == 2'd1) ? pc_b : (sel == 2'd2) ? pc_r : (sel == 2'd3) ? pc_j : 32'd0;
      @(negedge clock);
      capture();
      chk("mem_req", {31'd0, o_req}, {31'd0, e_req});
      if (e_req) chk("mem_addr", o_addr, e_addr);
      chk("valid_out", {31'd0, o_val}, {31'd0, e_val});
      chk("instr", o_instr, e_d);
      chk("pc_out", o_pc, e_pc);
      chk("pc4", o_pc4, e_val ? e_pc + 32'd4 : 32'd0);
      chk("level", o_level, q_pc.size());
      @(posedge clock); #1;
      if (sel != 2'd0) begin
         q_pc.delete(); q_d.delete();
         m_disc  = e_req && !mr;
         m_fetch = tgt;
      end else begin
         if (!was_empty && ri) begin
            void'(q_pc.pop_front()); void'(q_d.pop_front());
         end
         if (resp) begin
            if (m_disc) m_disc = 1'b0;
            else begin
               if (!(was_empty && e_val && ri)) begin
                  q_pc.push_back(e_addr); q_d.push_back(rd);
               end
               m_fetch = m_fetch + 32'd4;
            end
         end
      end
      m_pend = e_req && !mr;
      m_pend_addr = e_addr;
   endtask

   function automatic logic [31:0] rnd_addr();
      return ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
   endfunction

   initial begin
      @(posedge clock); #1;
      // sequential stream, zero-wait memory
      do_reset();
      cycle(2'd0, 1'b1, 1'b1, 32'hA000_0000); chk("seq_addr0", o_addr, 32'h100);
      cycle(2'd0, 1'b1, 1'b1, 32'hA000_0001); chk("seq_addr1", o_addr, 32'h104);
      cycle(2'd0, 1'b1, 1'b1, 32'hA000_0002); chk("seq_addr2", o_addr, 32'h108);

      // fill to DEPTH with ID stalled, then one pop reopens fetch
      do_reset();
      for (int i = 0; i < 4; i++) cycle(2'd0, 1'b1, 1'b0, 32'hB000_0000 + i);
      cycle(2'd0, 1'b1, 1'b0, 32'hBBBB_BBBB);
      chk("full_level", o_level, 32'd4);
      chk("full_req", {31'd0, o_req}, 32'd0);
      cycle(2'd0, 1'b1, 1'b1, 32'hBBBB_BBBB);
      cycle(2'd0, 1'b0, 1'b0, 32'hBBBB_BBBB);
      chk("refill_req", {31'd0, o_req}, 32'd1);
      chk("refill_addr", o_addr, 32'h110);

      // memory wait states, then jump redirect over an outstanding request
      do_reset();
      cycle(2'd0, 1'b1, 1'b0, 32'hC000_0000);
      for (int i = 0; i < 3; i++) begin
         cycle(2'd0, 1'b0, 1'b0, 32'hC0DE_0000);
         chk("stall_addr", o_addr, 32'h104);
      end
      cycle(2'd0, 1'b1, 1'b0, 32'hDEAD_BEEF);
      cycle(2'd0, 1'b0, 1'b1, 32'h0);
      cycle(2'd0, 1'b0, 1'b0, 32'h0);
      chk("stall_pc", o_pc, 32'h104);
      chk("stall_instr", o_instr, 32'hDEAD_BEEF);
      pc_b = 32'h0; pc_r = 32'h0; pc_j = 32'h400;
      cycle(2'd3, 1'b0, 1'b0, 32'h0);
      cycle(2'd0, 1'b1, 1'b0, 32'h1108_1108);
      chk("jmp_flush_valid", {31'd0, o_val}, 32'd0);
      chk("jmp_held_addr", o_addr, 32'h108);
      cycle(2'd0, 1'b1, 1'b0, 32'h4000_0400);
      chk("jmp_addr", o_addr, 32'h400);
      cycle(2'd0, 1'b0, 1'b0, 32'h0);
      chk("jmp_pc", o_pc, 32'h400);

      // branch redirect in the same cycle as a pop
      pc_b = 32'h200; pc_j = 32'h0;
      cycle(2'd1, 1'b0, 1'b1, 32'h0);
      cycle(2'd0, 1'b0, 1'b0, 32'h0);
      chk("br_level", o_level, 32'd0);
      cycle(2'd0, 1'b1, 1'b0, 32'h0404_0404);
      cycle(2'd0, 1'b1, 1'b0, 32'h0200_0200);
      cycle(2'd0, 1'b0, 1'b0, 32'h0);
      chk("br_pc", o_pc, 32'h200);

      // address wrap
      pc_r = 32'hFFFF_FFFC;
      cycle(2'd2, 1'b0, 1'b0, 32'h0);
      cycle(2'd0, 1'b1, 1'b0, 32'h0);
      cycle(2'd0, 1'b1, 1'b0, 32'hFFFF_0001);
      chk("wrap_addr_hi", o_addr, 32'hFFFF_FFFC);
      cycle(2'd0, 1'b1, 1'b0, 32'hFFFF_0002);
      chk("wrap_addr_lo", o_addr, 32'h0);
      chk("wrap_pc", o_pc, 32'hFFFF_FFFC);
      chk("wrap_pc4", o_pc4, 32'h0);

      // random traffic against the model
      for (int i = 0; i < 600; i++) begin
         logic [1:0] sel;
         if (i == 300) begin
            pc_select = 2'd0; mem_ready = 1'b0;
            cycle(2'd0, 1'b0, 1'b0, 32'h0);
            do_reset();
         end
         pc_b = rnd_addr(); pc_r = rnd_addr(); pc_j = rnd_addr();
         sel = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         cycle(sel, 1'($urandom_range(0, 1)),
               (i % 100 < 30) ? 1'b0 : 1'($urandom_range(0, 3) != 0), $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
